// File: rtl/sc_ddr_scrub_pkg.sv
// rtl/sc_ddr_scrub_pkg.sv - shared types and AXI constants for the DDR scrubber
package sc_ddr_scrub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ADDR,
        ST_DATA
    } scrub_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(input int data_w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_w / 8)) s = 3'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/sc_sat_counter.sv
// rtl/sc_sat_counter.sv - event counter that holds at all-ones
module sc_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sc_ddr_scrubber.sv
// rtl/sc_ddr_scrubber.sv - background AXI4 read scrubber walking an ECC-protected DDR region
module sc_ddr_scrubber
    import sc_ddr_scrub_pkg::*;
#(
    parameter int          ADDR_W       = 40,
    parameter int          DATA_W       = 128,
    parameter int          BURST_LEN    = 16,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter logic [63:0] REGION_BYTES = 64'h8000_0000,
    parameter int          INTERVAL_CYC = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              EN,
    input  logic              ECC_CE,
    input  logic              ECC_UE,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic              BUSY,
    output logic [31:0]       PASS_CNT,
    output logic [15:0]       CE_CNT,
    output logic [15:0]       UE_CNT,
    output logic [15:0]       RESP_ERR_CNT,
    output logic              PROTO_ERR
);

    localparam logic [63:0]       BURST_BYTES = 64'(BURST_LEN) * 64'(DATA_W / 8);
    localparam logic [ADDR_W-1:0] BASE_A      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] END_A       = ADDR_W'(BASE_ADDR + REGION_BYTES);
    localparam logic [ADDR_W-1:0] STEP_A      = ADDR_W'(BURST_BYTES);
    localparam int                IW          = $clog2(INTERVAL_CYC + 1);
    localparam logic [IW-1:0]     ICNT_LOAD   = IW'(INTERVAL_CYC - 1);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
        $error("BURST_LEN must be in 1..256");
    end
    if ((BASE_ADDR % BURST_BYTES) != 64'd0) begin : g_bad_base
        $error("BASE_ADDR must be aligned to the burst size");
    end
    if (REGION_BYTES == 64'd0 || (REGION_BYTES % BURST_BYTES) != 64'd0) begin : g_bad_region
        $error("REGION_BYTES must be a nonzero multiple of the burst size");
    end
    if (INTERVAL_CYC < 1) begin : g_bad_interval
        $error("INTERVAL_CYC must be at least 1");
    end

    scrub_state_t      state, state_nxt;
    logic [IW-1:0]     icnt;
    logic              icnt_load;
    logic [7:0]        beat_cnt;
    logic              ar_fire, beat_fire, beat_last, burst_end, wrap;
    logic [ADDR_W-1:0] addr_inc;
    logic              unused_rdata;

    assign unused_rdata = ^M_AXI_RDATA;

    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_ARSIZE  = axi_size(DATA_W);
    assign M_AXI_ARBURST = AXI_BURST_INCR;

    assign ar_fire   = M_AXI_ARVALID & M_AXI_ARREADY;
    assign beat_fire = M_AXI_RVALID & M_AXI_RREADY;
    assign beat_last = (beat_cnt == LAST_BEAT);
    // A burst closes on RLAST or on the expected final beat, whichever comes first.
    assign burst_end = beat_fire & (M_AXI_RLAST | beat_last);
    assign addr_inc  = M_AXI_ARADDR + STEP_A;
    assign wrap      = (addr_inc == END_A);

    assign BUSY = EN | (state == ST_ADDR) | (state == ST_DATA);

    always_comb begin
        state_nxt = state;
        icnt_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EN) begin
                    state_nxt = ST_WAIT;
                    icnt_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!EN) begin
                    state_nxt = ST_IDLE;
                end else if (icnt == '0) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ar_fire) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (burst_end) begin
                    state_nxt = EN ? ST_WAIT : ST_IDLE;
                    icnt_load = EN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= ST_IDLE;
            icnt          <= '0;
            beat_cnt      <= '0;
            M_AXI_ARADDR  <= BASE_A;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            PROTO_ERR     <= 1'b0;
        end else begin
            state         <= state_nxt;
            M_AXI_ARVALID <= (state_nxt == ST_ADDR);
            M_AXI_RREADY  <= (state_nxt == ST_DATA);
            // Load with INTERVAL_CYC-1 so WAIT lasts exactly INTERVAL_CYC cycles.
            if (icnt_load) begin
                icnt <= ICNT_LOAD;
            end else if (state == ST_WAIT && icnt != '0) begin
                icnt <= icnt - IW'(1);
            end
            if (state != ST_DATA) begin
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (beat_fire && (M_AXI_RLAST != beat_last)) begin
                PROTO_ERR <= 1'b1;
            end
            if (burst_end) begin
                M_AXI_ARADDR <= wrap ? BASE_A : addr_inc;
            end
        end
    end

    sc_sat_counter #(.W(32)) u_pass_cnt (
        .clk    (ACLK),
        .resetn (ARESETN),
        .inc    (burst_end & wrap),
        .cnt    (PASS_CNT)
    );

    sc_sat_counter #(.W(16)) u_ce_cnt (
        .clk    (ACLK),
        .resetn (ARESETN),
        .inc    (ECC_CE),
        .cnt    (CE_CNT)
    );

    sc_sat_counter #(.W(16)) u_ue_cnt (
        .clk    (ACLK),
        .resetn (ARESETN),
        .inc    (ECC_UE),
        .cnt    (UE_CNT)
    );

    sc_sat_counter #(.W(16)) u_resp_err_cnt (
        .clk    (ACLK),
        .resetn (ARESETN),
        .inc    (beat_fire & (M_AXI_RRESP != AXI_RESP_OKAY)),
        .cnt    (RESP_ERR_CNT)
    );

endmodule
